// File: rtl/rx_aurora_64to32_gearbox_pkg.sv
// ---------------------------------------------------------------------------
// rx_aurora_64to32_gearbox_pkg
// Shared definitions for the Aurora RX datapath modules.
//   gb_state_t      : gearbox FSM state encoding (IDLE, HDR, HI, LO)
//   K_HDR_TAG       : 4-bit marker placed in the top nibble of a K header word
//   k_header_word() : builds the 32-bit header word emitted ahead of a K entry
// ---------------------------------------------------------------------------
package rx_aurora_64to32_gearbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } gb_state_t;

    localparam logic [3:0] K_HDR_TAG = 4'hF;

    // Header layout: {tag, source id, 24 zero bits}
    function automatic logic [31:0] k_header_word(input logic [3:0] id);
        return {K_HDR_TAG, id, 24'h000000};
    endfunction

endpackage

// File: rtl/rx_aurora_64to32_gearbox_if.sv
// ---------------------------------------------------------------------------
// rx_aurora_64to32_gearbox_if
// Bundles the upstream FWFT FIFO read side and the downstream 32-bit FIFO-style
// output side of the gearbox.
//   IN_DATA/IN_IS_K/IN_EMPTY : head entry of the upstream FIFO
//   IN_READ                  : pop pulse towards the upstream FIFO
//   FIFO_READ                : consumer pops the current output word
//   FIFO_EMPTY/FIFO_DATA     : output word availability and value
// Modport slave is the gearbox view; master is the environment view.
// ---------------------------------------------------------------------------
interface rx_aurora_64to32_gearbox_if;
    logic [63:0] IN_DATA;
    logic        IN_IS_K;
    logic        IN_EMPTY;
    logic        IN_READ;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;

    modport slave (
        input  IN_DATA,
        input  IN_IS_K,
        input  IN_EMPTY,
        input  FIFO_READ,
        output IN_READ,
        output FIFO_EMPTY,
        output FIFO_DATA
    );

    modport master (
        output IN_DATA,
        output IN_IS_K,
        output IN_EMPTY,
        output FIFO_READ,
        input  IN_READ,
        input  FIFO_EMPTY,
        input  FIFO_DATA
    );
endinterface

// File: rtl/rx_aurora_64to32_gearbox.sv
// ---------------------------------------------------------------------------
// rx_aurora_64to32_gearbox
// Converts 64-bit entries from an upstream FWFT FIFO into a stream of 32-bit
// words presented with FIFO-style handshake. Data entries produce two words
// (high half, low half); user-K entries are preceded by a header word carrying
// the source IDENTIFIER, giving three words.
// Ports:
//   CLK    : rising-edge clock
//   RST_N  : asynchronous active-low reset
//   bus    : upstream/downstream handshake bundle (slave modport)
//   FLUSH  : synchronous discard of the held entry
//   K_CNT  : number of K entries fully emitted (wraps at 16 bits)
// ---------------------------------------------------------------------------
module rx_aurora_64to32_gearbox
    import rx_aurora_64to32_gearbox_pkg::*;
#(
    parameter int unsigned IDENTIFIER = 0
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    rx_aurora_64to32_gearbox_if.slave       bus,
    input  logic                            FLUSH,
    output logic [15:0]                     K_CNT
);

    localparam logic [3:0] ID_TAG = IDENTIFIER[3:0];

    gb_state_t   state;
    gb_state_t   state_next;
    logic [64:0] entry;        // {is_k, data}
    logic [15:0] k_cnt;
    logic        load;
    logic        k_done;
    logic        in_read;

    // Next-state / handshake decode
    always_comb begin
        state_next = state;
        load       = 1'b0;
        k_done     = 1'b0;
        in_read    = 1'b0;

        if (FLUSH) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!bus.IN_EMPTY) begin
                        in_read    = 1'b1;
                        load       = 1'b1;
                        state_next = bus.IN_IS_K ? ST_HDR : ST_HI;
                    end
                end
                ST_HDR: begin
                    if (bus.FIFO_READ) state_next = ST_HI;
                end
                ST_HI: begin
                    if (bus.FIFO_READ) state_next = ST_LO;
                end
                ST_LO: begin
                    if (bus.FIFO_READ) begin
                        k_done = entry[64];
                        // Chain straight into the next entry so a continuous
                        // reader sees no empty bubble between entries.
                        if (!bus.IN_EMPTY) begin
                            in_read    = 1'b1;
                            load       = 1'b1;
                            state_next = bus.IN_IS_K ? ST_HDR : ST_HI;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            entry <= '0;
        end else if (FLUSH) begin
            entry <= '0;
        end else if (load) begin
            entry <= {bus.IN_IS_K, bus.IN_DATA};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k_cnt <= '0;
        end else if (k_done) begin
            k_cnt <= k_cnt + 16'd1;
        end
    end

    // Output word select
    always_comb begin
        bus.FIFO_DATA = 32'h0;
        unique case (state)
            ST_HDR:  bus.FIFO_DATA = k_header_word(ID_TAG);
            ST_HI:   bus.FIFO_DATA = entry[63:32];
            ST_LO:   bus.FIFO_DATA = entry[31:0];
            default: bus.FIFO_DATA = 32'h0;
        endcase
    end

    // The pop is combinational from IN_EMPTY, so it is gated with reset to
    // keep the upstream FIFO untouched while reset is held.
    assign bus.IN_READ    = in_read & RST_N;
    assign bus.FIFO_EMPTY = (state == ST_IDLE);
    assign K_CNT          = k_cnt;

endmodule

// File: tb/tb_rx_aurora_64to32_gearbox.sv
// ---------------------------------------------------------------------------
// tb_rx_aurora_64to32_gearbox
// Self-checking bench: an upstream FIFO queue feeds the gearbox, and a model
// keeps the list of words still owed for the entry the gearbox holds.
// ---------------------------------------------------------------------------
module tb_rx_aurora_64to32_gearbox;

    localparam logic [3:0] TB_ID = 4'd3;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FLUSH;
    logic [15:0] K_CNT;

    rx_aurora_64to32_gearbox_if bus_if ();

    rx_aurora_64to32_gearbox #(.IDENTIFIER(3)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_if),
        .FLUSH (FLUSH),
        .K_CNT (K_CNT)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    logic [64:0] up_q[$];
    logic [31:0] cur[$];
    logic        cur_is_k;
    logic [15:0] exp_k;
    int          rd_pulses;
    int          ncyc;
    logic [31:0] hdr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_k, input logic [63:0] d);
        up_q.push_back({is_k, d});
    endtask

    task automatic drive_up();
        bus_if.IN_EMPTY = (up_q.size() == 0);
        if (up_q.size() == 0) begin
            bus_if.IN_DATA = 64'h0;
            bus_if.IN_IS_K = 1'b0;
        end else begin
            bus_if.IN_DATA = up_q[0][63:0];
            bus_if.IN_IS_K = up_q[0][64];
        end
    endtask

    // One clock cycle, entered just after a falling edge.
    task automatic cycle(input logic rd, input logic fl);
        logic        exp_rd;
        logic [64:0] e;
        logic [31:0] exp_data;
        drive_up();
        bus_if.FIFO_READ = rd;
        FLUSH = fl;
        #1;
        exp_data = (cur.size() == 0) ? 32'h0 : cur[0];
        exp_rd = !fl && (up_q.size() > 0) && (cur.size() == 0 || (rd && cur.size() == 1));
        check("fifo_empty", bus_if.FIFO_EMPTY, cur.size() == 0);
        check("fifo_data", bus_if.FIFO_DATA, exp_data);
        check("in_read", bus_if.IN_READ, exp_rd);
        check("k_cnt", K_CNT, exp_k);
        if (bus_if.IN_READ) rd_pulses++;
        if (fl) begin
            cur.delete();
        end else if (rd && cur.size() > 0) begin
            void'(cur.pop_front());
            if (cur.size() == 0 && cur_is_k) exp_k++;
        end
        if (exp_rd) begin
            e = up_q.pop_front();
            cur_is_k = e[64];
            if (e[64]) cur.push_back(hdr);
            cur.push_back(e[63:32]);
            cur.push_back(e[31:0]);
        end
        @(negedge CLK);
    endtask

    task automatic run_drain(input int max, input logic rand_rd, output int n);
        logic done;
        n = 0;
        while ((up_q.size() > 0 || cur.size() > 0) && n < max) begin
            cycle(rand_rd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        done = (up_q.size() == 0 && cur.size() == 0);
        check("drain_done", done, 1);
    endtask

    initial begin
        hdr      = {4'hF, TB_ID, 24'h000000};
        exp_k    = 16'h0;
        cur_is_k = 1'b0;
        rd_pulses = 0;
        RST_N    = 1'b0;
        FLUSH    = 1'b0;
        bus_if.FIFO_READ = 1'b0;
        push(1'b0, 64'h0123_4567_89AB_CDEF);
        drive_up();

        // Reset state, with an entry already waiting upstream
        @(negedge CLK);
        #1;
        check("rst_empty", bus_if.FIFO_EMPTY, 1);
        check("rst_data", bus_if.FIFO_DATA, 0);
        check("rst_in_read", bus_if.IN_READ, 0);
        check("rst_kcnt", K_CNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Single data entry, continuous read
        run_drain(10, 1'b0, ncyc);
        cycle(1'b1, 1'b0);

        // Single K entry
        push(1'b1, 64'h1111_2222_3333_4444);
        run_drain(10, 1'b0, ncyc);
        cycle(1'b0, 1'b0);
        check("k_one", K_CNT, 16'd1);

        // Four back-to-back data entries
        rd_pulses = 0;
        for (int i = 0; i < 4; i++) push(1'b0, {$urandom, $urandom});
        run_drain(20, 1'b0, ncyc);
        check("b2b_reads", rd_pulses, 4);
        check("b2b_cycles", ncyc, 9);

        // K entry held in HI for 5 cycles, then flushed with a read pending
        push(1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
        push(1'b0, 64'h5555_6666_7777_8888);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        rd_pulses = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        check("hold_reads", rd_pulses, 0);
        check("hold_data", bus_if.FIFO_DATA, 64'hAAAA_BBBB);
        cycle(1'b1, 1'b1);
        check("flush_kcnt", K_CNT, 16'd1);
        run_drain(10, 1'b0, ncyc);

        // Randomized traffic with random read gaps and occasional flushes
        for (int i = 0; i < 400; i++) begin
            if (up_q.size() < 4 && $urandom_range(0, 2) == 0)
                push(1'($urandom_range(0, 1)), {$urandom, $urandom});
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
        end
        run_drain(400, 1'b1, ncyc);

        // Reset pulsed while the low half is being presented
        push(1'b0, {$urandom, $urandom});
        push(1'b0, {$urandom, $urandom});
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        drive_up();
        bus_if.FIFO_READ = 1'b1;
        check("pre_rst_lo", cur.size(), 1);
        RST_N = 1'b0;
        #1;
        check("midrst_empty", bus_if.FIFO_EMPTY, 1);
        check("midrst_kcnt", K_CNT, 0);
        check("midrst_in_read", bus_if.IN_READ, 0);
        check("midrst_data", bus_if.FIFO_DATA, 0);
        cur.delete();
        exp_k = 16'h0;
        @(negedge CLK);
        RST_N = 1'b1;
        run_drain(10, 1'b0, ncyc);

        // K counter wrap: 65535 K entries, then one more
        for (int i = 0; i < 65535; i++) push(1'b1, {$urandom, $urandom});
        run_drain(200000, 1'b0, ncyc);
        check("k_cnt_ffff", K_CNT, 16'hFFFF);
        push(1'b1, 64'hDEAD_BEEF_0BAD_F00D);
        run_drain(10, 1'b0, ncyc);
        check("k_cnt_wrap", K_CNT, 16'h0000);
        cycle(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
